shared_mem_responder: RTL

Memory-side responder for the core's shared instruction/operand address path. It accepts one request at a time: an address already selected between instruction fetch and operand access, plus a select tag and optional write. After a fixed, parameterised number of wait states it returns read data or a write acknowledgement. It sits directly downstream of the address multiplexer and models the unified (von Neumann) memory of the multicycle core.

---
 rtl/mem_pkg.sv | 24 ++
 rtl/shared_mem_responder_if.sv | 35 +++
 rtl/mem_array.sv | 42 ++++
 rtl/shared_mem_responder.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the unified-memory responder.
// Select tags, FSM state encoding and default widths live here.
package mem_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LATENCY    = 2;
  localparam int CNT_WIDTH      = 4;

  localparam logic SEL_INST = 1'b0;
  localparam logic SEL_OP   = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter start value so that LATENCY wait cycles are spent in WAIT.
  function automatic logic [CNT_WIDTH-1:0] wait_load(input int latency);
    return (latency > 0) ? CNT_WIDTH'(latency - 1) : '0;
  endfunction

endpackage

// File: rtl/shared_mem_responder_if.sv
// Request/response bus between the core's address mux and the shared memory.
// Both channels use valid/ready: a transfer happens on a rising edge where
// valid and ready are both high; the sender holds its payload stable while
// valid is high and ready is low.
interface shared_mem_responder_if
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_sel;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_we;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_sel;
  logic                  resp_err;

  modport master (
    output req_valid, req_sel, req_addr, req_we, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_sel, resp_err
  );

  modport slave (
    input  req_valid, req_sel, req_addr, req_we, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data, resp_sel, resp_err
  );

endinterface

// File: rtl/mem_array.sv
// Register-file storage: one synchronous write port, one asynchronous read
// port, every word cleared by the asynchronous active-low reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/shared_mem_responder.sv
// Unified instruction/operand memory responder: one outstanding request,
// LATENCY wait states, then a registered response held until accepted.
module shared_mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                    clk,
  input  logic                    rst_n,
  shared_mem_responder_if.slave   bus,
  output state_t                  dbg_state
);

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = wait_load(LATENCY);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   sel_q, sel_d;
  logic                   we_q, we_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]  resp_data_q, resp_data_d;
  logic                   resp_sel_q, resp_sel_d;
  logic                   resp_err_q, resp_err_d;
  logic                   req_ready_q, req_ready_d;
  logic                   resp_valid_q, resp_valid_d;

  logic [ADDR_WIDTH-1:0]  cur_addr;
  logic                   cur_sel;
  logic                   cur_we;
  logic [DATA_WIDTH-1:0]  cur_wdata;
  logic                   enter_resp;
  logic                   legal_wr;
  logic                   mem_we;
  logic [DATA_WIDTH-1:0]  mem_rdata;

  mem_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (cur_addr),
    .wdata (cur_wdata),
    .raddr (cur_addr),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    sel_d       = sel_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    resp_data_d = resp_data_q;
    resp_sel_d  = resp_sel_q;
    resp_err_d  = resp_err_q;
    enter_resp  = 1'b0;
    // With zero wait states the response is built from the live request.
    cur_addr    = addr_q;
    cur_sel     = sel_q;
    cur_we      = we_q;
    cur_wdata   = wdata_q;

    unique case (state_q)
      IDLE: begin
        cur_addr  = bus.req_addr;
        cur_sel   = bus.req_sel;
        cur_we    = bus.req_we;
        cur_wdata = bus.req_wdata;
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          sel_d   = bus.req_sel;
          we_d    = bus.req_we;
          wdata_d = bus.req_wdata;
          cnt_d   = CNT_LOAD;
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Writes commit on the RESP entry edge, so a reset in WAIT drops them.
    legal_wr = cur_we && (cur_sel == SEL_OP);
    mem_we   = enter_resp && legal_wr;
    if (enter_resp) begin
      resp_data_d = legal_wr ? cur_wdata : mem_rdata;
      resp_sel_d  = cur_sel;
      resp_err_d  = cur_we && (cur_sel == SEL_INST);
    end

    req_ready_d  = (state_d == IDLE);
    resp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      sel_q        <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      resp_data_q  <= '0;
      resp_sel_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      resp_data_q  <= resp_data_d;
      resp_sel_q   <= resp_sel_d;
      resp_err_q   <= resp_err_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_sel   = resp_sel_q;
  assign bus.resp_err   = resp_err_q;
  assign dbg_state      = state_q;

endmodule
